// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 message padder.
// Covers the FSM state encoding, block geometry and last-word masking.
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        EXTRA = 2'd2
    } state_e;

    localparam int SHA_WORD_W    = 32;
    localparam int SHA_BLK_W     = 512;
    localparam int SHA_LEN_WORDS = 2;
    localparam int SHA_BLK_WORDS = SHA_BLK_W / SHA_WORD_W;

    // Keeps the first n bytes (big-endian), puts 0x80 at byte n when n < 4, zeroes the rest.
    function automatic logic [SHA_WORD_W-1:0] sha_mask_word(input logic [SHA_WORD_W-1:0] data,
                                                            input logic [2:0] n);
        logic [SHA_WORD_W-1:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(n))
                w[31-8*b -: 8] = data[31-8*b -: 8];
            else if (b == int'(n))
                w[31-8*b -: 8] = 8'h80;
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs a 32-bit word stream into 512-bit blocks,
// appends the 0x80 marker and bit length, and flags first/last blocks.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [SHA_WORD_W-1:0] in_data_i,
    input  logic                  in_last_i,
    input  logic [2:0]            in_nbytes_i,
    output logic                  blk_valid_o,
    input  logic                  blk_ready_i,
    output logic [SHA_BLK_W-1:0]  blk_data_o,
    output logic                  blk_first_o,
    output logic                  blk_last_o,
    output logic                  busy_o
);

    state_e                state_q, state_d;
    logic [SHA_WORD_W-1:0] buf_q [SHA_BLK_WORDS];
    logic [SHA_WORD_W-1:0] buf_d [SHA_BLK_WORDS];
    logic [3:0]            widx_q, widx_d;
    logic [LEN_W-1:0]      bcnt_q, bcnt_d;
    logic                  first_pend_q, first_pend_d;
    logic                  extra_pend_q, extra_pend_d;
    logic                  pad_in_extra_q, pad_in_extra_d;
    logic                  blk_last_q, blk_last_d;
    logic                  in_ready_q, blk_valid_q, blk_first_q, blk_flag_last_q, busy_q;

    logic [2:0]            n_clamp;
    logic [LEN_W-1:0]      bcnt_last;
    logic [6:0]            pad_pos;
    logic [63:0]           len_last, len_cur;

    assign n_clamp   = (in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
    assign bcnt_last = bcnt_q + LEN_W'(n_clamp);
    assign pad_pos   = {1'b0, widx_q, 2'b00} + {4'b0000, n_clamp};
    assign len_last  = 64'(bcnt_last) << 3;
    assign len_cur   = 64'(bcnt_q) << 3;

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        widx_d         = widx_q;
        bcnt_d         = bcnt_q;
        first_pend_d   = first_pend_q;
        extra_pend_d   = extra_pend_q;
        pad_in_extra_d = pad_in_extra_q;
        blk_last_d     = blk_last_q;

        if (clr_i) begin
            state_d        = FILL;
            for (int k = 0; k < SHA_BLK_WORDS; k++) buf_d[k] = '0;
            widx_d         = '0;
            bcnt_d         = '0;
            first_pend_d   = 1'b1;
            extra_pend_d   = 1'b0;
            pad_in_extra_d = 1'b0;
            blk_last_d     = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid_i && !in_last_i) begin
                        buf_d[widx_q] = in_data_i;
                        widx_d        = widx_q + 4'd1;
                        bcnt_d        = bcnt_q + LEN_W'(4);
                        if (widx_q == 4'd15) begin
                            state_d    = EMIT;
                            blk_last_d = 1'b0;
                        end
                    end else if (in_valid_i) begin
                        bcnt_d = bcnt_last;
                        // Slots after the last word are stale from earlier blocks: clear them,
                        // placing the pad byte in the next slot when the last word was full.
                        for (int k = 0; k < SHA_BLK_WORDS; k++) begin
                            if (k > int'(widx_q))
                                buf_d[k] = (k == int'(widx_q) + 1 && n_clamp == 3'd4)
                                           ? 32'h8000_0000 : '0;
                        end
                        buf_d[widx_q] = sha_mask_word(in_data_i, n_clamp);
                        if (pad_pos <= 7'd55) begin
                            buf_d[14]  = len_last[63:32];
                            buf_d[15]  = len_last[31:0];
                            blk_last_d = 1'b1;
                        end else begin
                            extra_pend_d   = 1'b1;
                            pad_in_extra_d = (pad_pos == 7'd64);
                            blk_last_d     = 1'b0;
                        end
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (blk_ready_i) begin
                        first_pend_d = 1'b0;
                        widx_d       = '0;
                        if (extra_pend_q) begin
                            state_d = EXTRA;
                        end else if (blk_last_q) begin
                            state_d      = FILL;
                            bcnt_d       = '0;
                            first_pend_d = 1'b1;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
                EXTRA: begin
                    for (int k = 0; k < SHA_BLK_WORDS; k++) buf_d[k] = '0;
                    buf_d[0]       = pad_in_extra_q ? 32'h8000_0000 : 32'h0;
                    buf_d[14]      = len_cur[63:32];
                    buf_d[15]      = len_cur[31:0];
                    extra_pend_d   = 1'b0;
                    pad_in_extra_d = 1'b0;
                    blk_last_d     = 1'b1;
                    state_d        = EMIT;
                end
                default: state_d = FILL;
            endcase
        end
    end

    // Output flags are registered from next-state values so nothing is combinational.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FILL;
            for (int k = 0; k < SHA_BLK_WORDS; k++) buf_q[k] <= '0;
            widx_q          <= '0;
            bcnt_q          <= '0;
            first_pend_q    <= 1'b1;
            extra_pend_q    <= 1'b0;
            pad_in_extra_q  <= 1'b0;
            blk_last_q      <= 1'b0;
            in_ready_q      <= 1'b1;
            blk_valid_q     <= 1'b0;
            blk_first_q     <= 1'b0;
            blk_flag_last_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            widx_q          <= widx_d;
            bcnt_q          <= bcnt_d;
            first_pend_q    <= first_pend_d;
            extra_pend_q    <= extra_pend_d;
            pad_in_extra_q  <= pad_in_extra_d;
            blk_last_q      <= blk_last_d;
            in_ready_q      <= (state_d == FILL);
            blk_valid_q     <= (state_d == EMIT);
            blk_first_q     <= (state_d == EMIT) && first_pend_d;
            blk_flag_last_q <= (state_d == EMIT) && blk_last_d;
            busy_q          <= (bcnt_d != '0) || (widx_d != '0) || (state_d != FILL);
        end
    end

    for (genvar gi = 0; gi < SHA_BLK_WORDS; gi++) begin : g_blk
        assign blk_data_o[SHA_BLK_W-1-gi*SHA_WORD_W -: SHA_WORD_W] = buf_q[gi];
    end

    assign in_ready_o  = in_ready_q;
    assign blk_valid_o = blk_valid_q;
    assign blk_first_o = blk_first_q;
    assign blk_last_o  = blk_flag_last_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message padding and block assembly for the user-plugin SHA-256 path. Sits between the APB register front-end and the SHA-256 compression core. Accepts a big-endian 32-bit word stream carrying one message, applies FIPS 180-4 padding (0x80 byte, zero fill, 64-bit bit-length), and emits 512-bit blocks over a valid/ready handshake. Also marks the first and last block of each message so the core knows when to initialise and when to finalise.

## Interface
- `LEN_W`, default 32: width of the byte counter. The maximum message length is 2^LEN_W − 1 bytes.
- `clk_i`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `clr_i`  in  1  synchronous abort; drops any message in progress
- `in_valid_i`  in  1  input word valid
- `in_ready_o`  out  1  input word accepted when valid & ready
- `in_data_i`  in  32  message word, first byte in bits [31:24]
- `in_last_i`  in  1  this word ends the message
- `in_nbytes_i`  in  3  valid bytes in the last word, 0..4; ignored unless `in_last_i`
- `blk_valid_o`  out  1  block valid
- `blk_ready_i`  in  1  core accepts block
- `blk_data_o`  out  512  block; word 0 in [511:480], word 15 in [31:0]
- `blk_first_o`  out  1  first block of the message
- `blk_last_o`  out  1  final block of the message
- `busy_o`  out  1  a message is in progress or a block is pending

## Operation
- **Storage.**
  - 16×32 word buffer.
  - `widx` (4 bits): next word slot.
  - `bcnt` (`LEN_W` bits): message byte count, wraps modulo 2^LEN_W.
  - Flags: `first_pend`, `extra_pend`, `pad_in_extra`.
- **State FILL.**
  - `in_ready_o` = 1.
  - On a non-last word: store it at `widx`, then `widx`+1 and `bcnt`+4.
  - When the word lands in slot 15: go to EMIT with `blk_last` = 0.
- **Last word with n bytes.**
  - Data bytes at index ≥ n are forced to 0.
  - `bcnt` += n. Let p = `widx`·4 + n, the byte position of the pad byte.
  - p ≤ 55: write 0x80 at byte p and zeros through byte 55. Words 14–15 = {`bcnt`,3'b000}, zero-extended to 64 bits. Go to EMIT with `blk_last` = 1.
  - 56 ≤ p ≤ 63: write 0x80 at byte p and zeros to byte 63. Set `extra_pend`. Go to EMIT with `blk_last` = 0.
  - p = 64: no pad byte in this block. Set `extra_pend` and `pad_in_extra`. Go to EMIT with `blk_last` = 0.
- **State EMIT.**
  - `blk_valid_o` = 1; `in_ready_o` = 0.
  - `blk_data_o`, `blk_first_o` and `blk_last_o` are held stable until the handshake.
- **On EMIT handshake.**
  - Clear `first_pend`.
  - If `extra_pend`: go to EXTRA.
  - Else if `blk_last`: go to FILL, with `widx`, `bcnt` = 0 and `first_pend` = 1.
  - Else: go to FILL with `widx` = 0.
- **State EXTRA** (one cycle, no handshake).
  - Build the extra block: zeros, plus word 0 = 0x80000000 if `pad_in_extra`, plus words 14–15 = bit length.
  - Clear `extra_pend` and `pad_in_extra`.
  - Go to EMIT with `blk_last` = 1 and `blk_first_o` = 0.
- **Flags.**
  - `blk_first_o` = `first_pend` while in EMIT.
  - A one-block message has `blk_first_o` and `blk_last_o` both 1.
- **`busy_o`.** 1 when `bcnt` ≠ 0, `widx` ≠ 0, or state ≠ FILL.
- **Empty message.** `in_last_i` with n = 0 at `widx` = 0 gives word 0 = 0x80000000 and length 0.
- **Illegal input.** `in_nbytes_i` > 4 is treated as 4.

## Timing
- **Reset values.** FILL, `in_ready_o` = 1, `blk_valid_o` = 0, `blk_data_o` = 0, `blk_first_o` = 0, `blk_last_o` = 0, `busy_o` = 0, `first_pend` = 1, other flags 0.
- **Throughput.** One word per cycle in FILL.
- **Latency.** `blk_valid_o` rises the cycle after the word that completes the block is accepted. The extra block asserts 2 cycles after the preceding handshake.
- **After a handshake.** `in_ready_o` returns the cycle after the EMIT handshake.
- **Registered outputs.** All outputs come from registers; no combinational path from `blk_ready_i` to `in_ready_o`.
- **`clr_i`.** Takes priority over everything. The next cycle is FILL with counters and flags at their reset values and `blk_valid_o` = 0, even if a block was pending. Async reset has the same effect at any point.

## Structure
- `sha256_pkg` holds:
  - the state enum `{FILL, EMIT, EXTRA}`;
  - the constants `SHA_WORD_W` = 32, `SHA_BLK_W` = 512, `SHA_LEN_WORDS` = 2;
  - a function `sha_mask_word(data, n)` that zeroes trailing bytes and inserts 0x80.
- Single module, no sub-module. The buffer is a flat register array.

## Test plan
- **"abc".** Word 0x61626300, last, n = 3 → one block: word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018, first = last = 1.
- **Empty message.** last, n = 0 at start → word 0 = 0x80000000, rest 0, first = last = 1.
- **56-byte message.** 14 words, last n = 4 → block 1: word 14 = 0x80000000, word 15 = 0, first = 1, last = 0. Block 2: all zero except word 15 = 0x000001C0, first = 0, last = 1.
- **64-byte message.** 16 words, last n = 4 → block 1 is the raw data, last = 0. Block 2: word 0 = 0x80000000, word 15 = 0x00000200, last = 1.
- **Backpressure.** Hold `blk_ready_i` = 0 for 5 cycles with a block pending → `blk_data_o` and flags stable, `in_ready_o` = 0. Release → one handshake, then `in_ready_o` = 1 on the next cycle.
- **Abort mid-message.** Assert `clr_i` after 7 words, then send "abc" → output is identical to the "abc" case with `blk_first_o` = 1. Repeat with async reset.
